// File: rtl/comparator_seq_if.sv
// Handshake bundle for comparator_seq: operand request channel and result channel.
interface comparator_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         eq;
  logic         lt;
  logic         ltu;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, lt, ltu, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, lt, ltu, busy
  );
endinterface

// File: rtl/comparator_seq.sv
// Multi-cycle eq / signed lt / unsigned ltu comparator scanning CHUNK bits per cycle, MSB chunk first.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to stop at the first differing chunk; otherwise latency is always N/CHUNK.

module comparator_eq #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);
  assign eq = (a == b);
endmodule

module comparator_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  comparator_seq_if.slave bus
);
  localparam int NCHUNK = N / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state;
  logic signed [N-1:0] a_q;
  logic signed [N-1:0] b_q;
  logic [IDX_W-1:0]    idx;
  logic                eq_q;
  logic                lt_q;
  logic                ltu_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
  logic                decided;
`endif

  logic [CHUNK-1:0]    chunk_a;
  logic [CHUNK-1:0]    chunk_b;
  logic                chunk_eq;
  logic                chunk_ltu;
  logic                chunk_lt;
  logic                top_chunk;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  comparator_eq #(.N(CHUNK)) u_chunk_eq (
    .a  (chunk_a),
    .b  (chunk_b),
    .eq (chunk_eq)
  );

  // With equal sign bits, two's-complement order matches unsigned order of the top chunk.
  assign top_chunk = (idx == IDX_TOP);
  assign chunk_ltu = (chunk_a < chunk_b);
  assign chunk_lt  = (top_chunk && (a_q[N-1] != b_q[N-1])) ? a_q[N-1] : chunk_ltu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
      decided     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            idx        <= IDX_TOP;
            state      <= COMPARE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            decided    <= 1'b0;
`endif
          end
        end

        COMPARE: begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
          if (!chunk_eq) begin
            eq_q        <= 1'b0;
            lt_q        <= chunk_lt;
            ltu_q       <= chunk_ltu;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else if (idx == '0) begin
            eq_q        <= 1'b1;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx - IDX_W'(1);
          end
`else
          // First differing chunk wins; later chunks only advance the scan.
          if (!decided && !chunk_eq) begin
            eq_q    <= 1'b0;
            lt_q    <= chunk_lt;
            ltu_q   <= chunk_ltu;
            decided <= 1'b1;
          end
          if (idx == '0) begin
            if (!decided && chunk_eq) begin
              eq_q  <= 1'b1;
              lt_q  <= 1'b0;
              ltu_q <= 1'b0;
            end
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx - IDX_W'(1);
          end
`endif
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.ltu       = ltu_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Randomized bench for comparator_seq against a plain-arithmetic reference of eq/lt/ltu and latency.
module tb_comparator_seq;
  localparam int N      = 32;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = N / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  comparator_seq_if #(.N(N)) bus ();

  comparator_seq #(.N(N), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of cycles from accept to out_valid.
  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    int k;
    bit stop;
    k = 0;
    stop = 1'b0;
    for (int c = NCHUNK - 1; c > 0; c--) begin
      if (!stop) begin
        if (((x >> (c * CHUNK)) & 32'hF) == ((y >> (c * CHUNK)) & 32'hF)) k++;
        else stop = 1'b1;
      end
    end
    return k + 1;
`else
    return NCHUNK;
`endif
  endfunction

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int stall);
    logic e_eq, e_lt, e_ltu;
    int   lat;
    int   w;
    e_eq  = (av == bv);
    e_lt  = ($signed(av) < $signed(bv));
    e_ltu = (av < bv);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.a        = $urandom;
    bus.b        = $urandom;
    check("cmp_busy", 32'(bus.busy), 32'd1);
    check("cmp_in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 4 * NCHUNK) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat(av, bv)));
    for (int s = 0; s <= stall; s++) begin
      check("eq", 32'(bus.eq), 32'(e_eq));
      check("lt", 32'(bus.lt), 32'(e_lt));
      check("ltu", 32'(bus.ltu), 32'(e_ltu));
      check("done_out_valid", 32'(bus.out_valid), 32'd1);
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      check("done_busy", 32'(bus.busy), 32'd1);
      if (s < stall) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.a         = $urandom;
        bus.b         = $urandom;
        tick();
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("ret_out_valid", 32'(bus.out_valid), 32'd0);
    check("ret_in_ready", 32'(bus.in_ready), 32'd1);
    check("ret_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int          mode;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_eq", 32'(bus.eq), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(32'h12345678, 32'h12345678, 5);
    do_op(32'h80000000, 32'h00000001, 0);
    do_op(32'h1234567A, 32'h1234567B, 2);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    do_op(32'hFFFFFFFE, 32'hFFFFFFFF, 0);

    // Abort an operation three cycles into its scan.
    bus.a        = 32'h00000000;
    bus.b        = 32'h00000010;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd1);
    repeat (3) tick();
    check("abort_pre_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy_clr", 32'(bus.busy), 32'd0);
    check("abort_eq", 32'(bus.eq), 32'd0);
    check("abort_lt", 32'(bus.lt), 32'd0);
    check("abort_ltu", 32'(bus.ltu), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_op(32'd5, 32'd5, 0);

    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 3);
      ra   = $urandom;
      case (mode)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = ra ^ ($urandom >> $urandom_range(0, 31));
      endcase
      do_op(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Multi-cycle magnitude/equality comparator with valid/ready handshakes on both sides.
- Latches two N-bit operands, then scans them CHUNK bits per cycle, MSB chunk first.
- Returns eq, signed lt and unsigned ltu together.
- Used where a full-width single-cycle compare breaks timing (e.g. multi-cycle branch unit, iterative divider control). Per-chunk equality is built from comparator_eq instances with N=CHUNK.

Parameters:
- N, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits examined per cycle; NCHUNK = N/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  first operand, two's complement.
- b  input  N  second operand, two's complement.
- out_valid  output  1  results are valid.
- out_ready  input  1  consumer accepts results.
- eq  output  1  a == b.
- lt  output  1  a < b, signed.
- ltu  output  1  a < b, unsigned.
- busy  output  1  high in COMPARE or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; latched operands, chunk index, eq, lt, ltu and out_valid all clear to 0.
  - in_ready is 0 while rst is high and 1 in IDLE after release.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a and b, set idx=NCHUNK-1, go to COMPARE.
  - COMPARE: one chunk per cycle. Chunk = bits [idx*CHUNK+CHUNK-1 : idx*CHUNK] of the latched operands.
    - Chunk differs: set eq=0. Set ltu = unsigned(chunk_a) < unsigned(chunk_b).
    - lt on the top chunk (idx=NCHUNK-1) with differing sign bits: lt = a[N-1]. Otherwise lt = ltu.
    - Chunk differs: go to DONE (early exit).
    - Chunks equal and idx==0: set eq=1, lt=0, ltu=0, go to DONE. Otherwise idx-- and stay in COMPARE.
  - DONE: out_valid=1. eq, lt and ltu are registered and stable. On out_valid&out_ready, go to IDLE on the next edge.
- Latency:
  - Let k = number of leading equal chunks (k = NCHUNK-1 when the operands are equal).
  - out_valid rises k+1 cycles after the accept edge.
  - Minimum latency 1, maximum NCHUNK.
- Throughput: one op per (latency + 1 + handshake) cycles. in_ready=0 in COMPARE and DONE; no overlap.
- a, b and in_valid are ignored outside IDLE. Operands are sampled only at the accept edge.
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely.
- in_valid may be held high across back-to-back ops. The next accept happens the cycle after returning to IDLE.
- Reset mid-operation aborts immediately with no partial result. The first op after release behaves as from cold reset.
- No X propagation: the result registers update only in COMPARE.

Optional Feature:
- Macro: COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: early exit as described; latency k+1.
- Undefined: constant latency NCHUNK for every op.
  - The FSM always scans through idx==0.
  - The first differing chunk's eq/lt/ltu decision is captured in a sticky "decided" flag; later chunks cannot overwrite it.
  - Results are identical to the defined case; only timing differs (data-independent timing).

Test Plan (N=32, CHUNK=4):
- Equal operands: a=b=0x12345678 -> out_valid 8 cycles after accept; eq=1, lt=0, ltu=0.
- Sign differs in top chunk: a=0x80000000, b=0x00000001 -> eq=0, lt=1, ltu=0. Latency 1 with _EN, 8 without.
- Differ in LSB chunk: a=0x1234567A, b=0x1234567B -> latency 8; eq=0, lt=1, ltu=1.
- Negative vs negative: a=0xFFFFFFFF (-1), b=0xFFFFFFFE (-2) -> eq=0, lt=0, ltu=0. Repeat with a and b swapped -> lt=1, ltu=1.
- Backpressure/ignore: hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid -> outputs stable, in_ready=0. Assert out_ready -> IDLE next cycle; a queued in_valid is accepted the cycle after.
- Reset mid-op: assert rst 3 cycles into COMPARE of a=0x00000000, b=0x00000010 -> all outputs 0 immediately, state IDLE. After release, a=5, b=5 -> eq=1 after 8 cycles.
